// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
// Holds default datapath widths, the control-bundle layout and the packed payload width helper.
// The control bundle is packed as {halt, memwrite, regwrite, memread, memtoreg}.
package ex_mem_pipe_reg_pkg;

  localparam int unsigned NBITS_DEF = 32;
  localparam int unsigned RBITS_DEF = 5;
  localparam int unsigned SBITS_DEF = 5;

  // Control-bundle width and bit positions
  localparam int unsigned CTRL_W        = 5;
  localparam int unsigned CTRL_MEMTOREG = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_HALT     = 4;

  // Payload layout, MSB first: {result, rt, rd, sizecontrol, ctrl}
  function automatic int unsigned payload_width(int unsigned nbits, int unsigned rbits,
                                                int unsigned sbits);
    return 2 * nbits + rbits + sbits + CTRL_W;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_slot.sv
// pipe_slot: one payload+valid register with load/clear/hold.
// Ports:
//   clk     clock (rising edge)
//   rst     synchronous active-high reset; clears valid and payload
//   clear   drop the held entry (valid -> 0, payload holds)
//   load    capture d and mark valid (clear has priority)
//   d       incoming payload
//   q       held payload
//   valid   slot holds a live entry
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// The main slot drives MEM_*; the skid slot catches one entry when MEM back-pressures.
// MEM_ controls are gated by MEM_valid so the MEM stage never acts on a bubble.
// A halt entry blocks further accepts until it retires, then sets sticky o_halted.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_flush, i_stall        discard all entries / freeze the stage
//   i_valid, o_ready        upstream handshake
//   i_mem_ready             MEM consumes the main slot this cycle
//   EX_*                    incoming payload and controls
//   MEM_valid, MEM_*        main-slot entry (controls gated by MEM_valid)
//   o_halted                sticky: a halt entry has retired into MEM
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned RBITS = RBITS_DEF,
  parameter int unsigned SBITS = SBITS_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mem_ready,
  input  logic [NBITS-1:0] EX_result,
  input  logic [NBITS-1:0] EX_Rt,
  input  logic [RBITS-1:0] EX_rd,
  input  logic [SBITS-1:0] EX_sizecontrol,
  input  logic             EX_memtoreg,
  input  logic             EX_memread,
  input  logic             EX_regwrite,
  input  logic             EX_memwrite,
  input  logic             EX_halt_flag,
  output logic             MEM_valid,
  output logic [NBITS-1:0] MEM_result,
  output logic [NBITS-1:0] MEM_Rt,
  output logic [RBITS-1:0] MEM_rd,
  output logic [SBITS-1:0] MEM_sizecontrol,
  output logic             MEM_memtoreg,
  output logic             MEM_memread,
  output logic             MEM_regwrite,
  output logic             MEM_memwrite,
  output logic             MEM_haltflag,
  output logic             o_halted
);

  localparam int unsigned PW = payload_width(NBITS, RBITS, SBITS);

  logic [CTRL_W-1:0] ex_ctrl;
  logic [PW-1:0]     ex_payload, main_q, skid_q, main_d;
  logic              main_valid, skid_valid;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              accept, consume;
  logic              halt_pending;
  logic [CTRL_W-1:0] main_ctrl;

  always_comb begin
    ex_ctrl                = '0;
    ex_ctrl[CTRL_MEMTOREG] = EX_memtoreg;
    ex_ctrl[CTRL_MEMREAD]  = EX_memread;
    ex_ctrl[CTRL_REGWRITE] = EX_regwrite;
    ex_ctrl[CTRL_MEMWRITE] = EX_memwrite;
    ex_ctrl[CTRL_HALT]     = EX_halt_flag;
  end

  assign ex_payload = {EX_result, EX_Rt, EX_rd, EX_sizecontrol, ex_ctrl};

  // i_rst term keeps o_ready low during the reset cycle itself
  assign o_ready = ~skid_valid & ~halt_pending & ~i_stall & ~o_halted & ~i_rst;
  // An entry offered during a flush is dropped
  assign accept  = i_valid & o_ready & ~i_flush;
  assign consume = main_valid & i_mem_ready & ~i_stall;

  // Slot moves; o_ready=0 whenever skid is full, so accept and skid->main never coincide
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = ex_payload;
    if (i_flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (consume && skid_valid) begin
      main_load  = 1'b1;
      main_d     = skid_q;
      skid_clear = 1'b1;
    end else if (accept && (!main_valid || consume)) begin
      main_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (consume) begin
      main_clear = 1'b1;
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (ex_payload),
    .q     (skid_q),
    .valid (skid_valid)
  );

  assign main_ctrl = main_q[CTRL_W-1:0];

  // Stall needs no explicit term: it already forces accept and consume low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halt_pending <= 1'b0;
      o_halted     <= 1'b0;
    end else if (i_flush) begin
      halt_pending <= 1'b0;
    end else if (consume && main_ctrl[CTRL_HALT]) begin
      halt_pending <= 1'b0;
      o_halted     <= 1'b1;
    end else if (accept && EX_halt_flag) begin
      halt_pending <= 1'b1;
    end
  end

  assign MEM_valid       = main_valid;
  assign MEM_result      = main_q[PW-1 -: NBITS];
  assign MEM_Rt          = main_q[PW-NBITS-1 -: NBITS];
  assign MEM_rd          = main_q[CTRL_W+SBITS +: RBITS];
  assign MEM_sizecontrol = main_q[CTRL_W +: SBITS];
  assign MEM_memtoreg    = main_valid & main_ctrl[CTRL_MEMTOREG];
  assign MEM_memread     = main_valid & main_ctrl[CTRL_MEMREAD];
  assign MEM_regwrite    = main_valid & main_ctrl[CTRL_REGWRITE];
  assign MEM_memwrite    = main_valid & main_ctrl[CTRL_MEMWRITE];
  assign MEM_haltflag    = main_valid & main_ctrl[CTRL_HALT];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, stall, valid, ready, mem_ready;
  logic [31:0] ex_result, ex_rt;
  logic [4:0]  ex_rd, ex_size;
  logic        ex_memtoreg, ex_memread, ex_regwrite, ex_memwrite, ex_halt;
  logic        mem_valid;
  logic [31:0] mem_result, mem_rt;
  logic [4:0]  mem_rd, mem_size;
  logic        mem_memtoreg, mem_memread, mem_regwrite, mem_memwrite, mem_halt;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_stall         (stall),
    .i_valid         (valid),
    .o_ready         (ready),
    .i_mem_ready     (mem_ready),
    .EX_result       (ex_result),
    .EX_Rt           (ex_rt),
    .EX_rd           (ex_rd),
    .EX_sizecontrol  (ex_size),
    .EX_memtoreg     (ex_memtoreg),
    .EX_memread      (ex_memread),
    .EX_regwrite     (ex_regwrite),
    .EX_memwrite     (ex_memwrite),
    .EX_halt_flag    (ex_halt),
    .MEM_valid       (mem_valid),
    .MEM_result      (mem_result),
    .MEM_Rt          (mem_rt),
    .MEM_rd          (mem_rd),
    .MEM_sizecontrol (mem_size),
    .MEM_memtoreg    (mem_memtoreg),
    .MEM_memread     (mem_memread),
    .MEM_regwrite    (mem_regwrite),
    .MEM_memwrite    (mem_memwrite),
    .MEM_haltflag    (mem_halt),
    .o_halted        (halted)
  );

  // Advance one edge; outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rt/rd/size are derived from result so payload checks are hand-computable
  task automatic drive(input logic v, input logic [31:0] res, input logic rw, input logic h);
    valid       = v;
    ex_result   = res;
    ex_rt       = ~res;
    ex_rd       = res[4:0] ^ 5'h15;
    ex_size     = res[8:4];
    ex_memtoreg = 1'b0;
    ex_memread  = 1'b0;
    ex_regwrite = rw;
    ex_memwrite = 1'b1;
    ex_halt     = h;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; mem_ready = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 1'b1);
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    step();
    step();
    vectors++;
    if ({mem_valid, mem_regwrite, mem_memwrite, mem_halt, halted} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {mem_valid, mem_regwrite, mem_memwrite, mem_halt, halted});
    end
    vectors++;
    if ({mem_result, mem_rt, mem_rd, mem_size} !== 74'h0) begin
      miscompares++; $display("FAIL reset_payload: result %h rt %h want 0", mem_result, mem_rt);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b0);
      #1;
      vectors++;
      if (ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ready);
      end
      step();
      vectors++;
      if (mem_valid !== 1'b1 || mem_result !== vals[i] || mem_regwrite !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_out[%0d]: valid %b result %h rw %b want 1 %h 1",
                 i, mem_valid, mem_result, mem_regwrite, vals[i]);
      end
    end
    // Other payload fields are carried verbatim
    vectors++;
    if (mem_rt !== 32'hFFFF_FFCF || mem_rd !== 5'h05 || mem_size !== 5'h03) begin
      miscompares++;
      $display("FAIL stream_fields: rt %h rd %h size %h want ffffffcf 05 03", mem_rt, mem_rd,
               mem_size);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    vectors++;
    if (mem_valid !== 1'b0 || mem_regwrite !== 1'b0 || mem_memwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drain: valid %b rw %b mw %b want 0 0 0", mem_valid, mem_regwrite,
               mem_memwrite);
    end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (ready !== 1'b0 || mem_result !== 32'hA) begin
      miscompares++; $display("FAIL bp_full: ready %b result %h want 0 a", ready, mem_result);
    end
    mem_ready = 1'b1;
    step();
    vectors++;
    if (mem_valid !== 1'b1 || mem_result !== 32'hB || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_skid: valid %b result %h ready %b want 1 b 1", mem_valid, mem_result,
               ready);
    end
    step();
    vectors++;
    if (mem_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_drain: valid %b want 0", mem_valid);
    end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b1, 1'b0);
    step();
    vectors++;
    if (mem_regwrite !== 1'b1 || mem_result !== 32'hA) begin
      miscompares++;
      $display("FAIL flush_pre: rw %b result %h want 1 a", mem_regwrite, mem_result);
    end
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (mem_valid !== 1'b0 || mem_regwrite !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: valid %b rw %b ready %b want 0 0 1", mem_valid, mem_regwrite,
               ready);
    end
    mem_ready = 1'b1;
    step();
    step();
    vectors++;
    if (mem_valid !== 1'b0 || mem_result === 32'hC) begin
      miscompares++; $display("FAIL flush_drop: valid %b result %h want 0 not-c", mem_valid,
                              mem_result);
    end
  endtask

  task automatic test_stall();
    mem_ready = 1'b0;
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h66, 1'b1, 1'b0);
    stall = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (mem_valid !== 1'b1 || mem_result !== 32'h55 || ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid %b result %h ready %b want 1 55 0", i, mem_valid,
                 mem_result, ready);
      end
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    vectors++;
    if (mem_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_release: valid %b want 0", mem_valid);
    end
  endtask

  task automatic test_halt();
    mem_ready = 1'b0;
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hEE, 1'b1, 1'b0);
    #1;
    vectors++;
    if (ready !== 1'b0 || mem_halt !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_pending: ready %b haltflag %b halted %b want 0 1 0", ready, mem_halt,
               halted);
    end
    step();
    mem_ready = 1'b1;
    step();
    vectors++;
    if (halted !== 1'b1 || mem_valid !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_retire: halted %b valid %b ready %b want 1 0 0", halted, mem_valid,
               ready);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    vectors++;
    if (halted !== 1'b1 || mem_valid !== 1'b0) begin
      miscompares++; $display("FAIL halt_sticky: halted %b valid %b want 1 0", halted, mem_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (halted !== 1'b0 || ready !== 1'b1) begin
      miscompares++; $display("FAIL halt_reset: halted %b ready %b want 0 1", halted, ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
